// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module   : mdu
// Purpose  : Multiply/divide unit holding the architectural HI/LO registers.
//            Operands arrive straight from the register file (rs = rd1,
//            rt = rd2). Multi-cycle latency is modelled by a busy flag so the
//            controller can stall mfhi/mflo and back-to-back MDU operations.
//            The result is computed at the accepting edge into shadow
//            registers and committed to HI/LO when the latency counter
//            expires.
// Ports    : clk      in   1   clock, all state updates on posedge
//            reset    in   1   synchronous, active-high
//            start    in   1   operation valid this cycle
//            op       in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                              4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
//            rs_data  in  32   operand A
//            rt_data  in  32   operand B
//            busy     out  1   high while a mult/div is in flight
//            hi       out 32   HI register
//            lo       out 32   LO register
// Params   : MULT_CYCLES  busy duration of MULT/MULTU/MADD/MSUB (>=1)
//            DIV_CYCLES   busy duration of DIV/DIVU (>=1)
// Config   : MDU_MADD_EN  when defined, ops 6/7 accumulate (MADD/MSUB) into
//                         {HI,LO}; when undefined they are ignored.
// Revision : 1.0  initial release
// ============================================================================
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MSUB  = 3'd7;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // How the shadow result is folded into {HI,LO} at completion.
   typedef enum logic [1:0] {
      MODE_LOAD = 2'd0,   // overwrite with shadow result
      MODE_ADD  = 2'd1,   // {hi,lo} + shadow
      MODE_SUB  = 2'd2,   // {hi,lo} - shadow
      MODE_NONE = 2'd3    // leave HI/LO untouched (divide by zero)
   } mode_t;

   state_t           state_q, state_d;
   mode_t            mode_q,  mode_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             busy_q,  busy_d;
   logic [31:0]      hi_q,    hi_d;
   logic [31:0]      lo_q,    lo_d;
   logic [63:0]      res_q,   res_d;

   // ------------------------------------------------------------------
   // Multiplier: both products are formed at full 64-bit width so the
   // low 64 bits of the 64x64 product are exactly the 32x32 result.
   // ------------------------------------------------------------------
   logic [63:0] a_sx, b_sx, a_zx, b_zx;
   logic [63:0] prod_s, prod_u;

   assign a_sx   = {{32{rs_data[31]}}, rs_data};
   assign b_sx   = {{32{rt_data[31]}}, rt_data};
   assign a_zx   = {32'd0, rs_data};
   assign b_zx   = {32'd0, rt_data};
   assign prod_s = a_sx * b_sx;
   assign prod_u = a_zx * b_zx;

   // ------------------------------------------------------------------
   // Divider: one unsigned divider shared by DIV and DIVU. For DIV the
   // operands are reduced to magnitudes and the signs re-applied, giving
   // truncation toward zero and a remainder carrying the dividend sign.
   // 0x80000000 has magnitude 0x80000000 as an unsigned value, so the
   // overflow case 0x80000000 / -1 naturally yields lo=0x80000000, hi=0.
   // ------------------------------------------------------------------
   logic        div_signed;
   logic        rs_neg, rt_neg;
   logic        div_by_zero;
   logic [31:0] mag_a, mag_b;
   logic [31:0] dividend, divisor;
   logic [31:0] quo_u, rem_u;
   logic [31:0] quo, rem;

   assign div_signed  = (op == OP_DIV);
   assign rs_neg      = div_signed & rs_data[31];
   assign rt_neg      = div_signed & rt_data[31];
   assign div_by_zero = (rt_data == 32'd0);
   assign mag_a       = rs_neg ? (32'd0 - rs_data) : rs_data;
   assign mag_b       = rt_neg ? (32'd0 - rt_data) : rt_data;
   assign dividend    = mag_a;
   // A zero divisor is replaced so the divider never sees x/0; the
   // result is discarded anyway in that case.
   assign divisor     = div_by_zero ? 32'd1 : mag_b;
   assign quo_u       = dividend / divisor;
   assign rem_u       = dividend % divisor;
   assign quo         = (rs_neg ^ rt_neg) ? (32'd0 - quo_u) : quo_u;
   assign rem         = rs_neg ? (32'd0 - rem_u) : rem_u;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   logic [63:0] acc;
   assign acc = {hi_q, lo_q};

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     res_d   = prod_s;
                     mode_d  = MODE_LOAD;
                     cnt_d   = MULT_LOAD;
                     busy_d  = 1'b1;
                     state_d = S_BUSY;
                  end
                  OP_MULTU: begin
                     res_d   = prod_u;
                     mode_d  = MODE_LOAD;
                     cnt_d   = MULT_LOAD;
                     busy_d  = 1'b1;
                     state_d = S_BUSY;
                  end
                  OP_DIV, OP_DIVU: begin
                     res_d   = {rem, quo};
                     mode_d  = div_by_zero ? MODE_NONE : MODE_LOAD;
                     cnt_d   = DIV_LOAD;
                     busy_d  = 1'b1;
                     state_d = S_BUSY;
                  end
                  OP_MTHI: hi_d = rs_data;
                  OP_MTLO: lo_d = rs_data;
`ifdef MDU_MADD_EN
                  // The accumulator is read at completion, not here, so
                  // only the product is captured now.
                  OP_MADD: begin
                     res_d   = prod_s;
                     mode_d  = MODE_ADD;
                     cnt_d   = MULT_LOAD;
                     busy_d  = 1'b1;
                     state_d = S_BUSY;
                  end
                  OP_MSUB: begin
                     res_d   = prod_s;
                     mode_d  = MODE_SUB;
                     cnt_d   = MULT_LOAD;
                     busy_d  = 1'b1;
                     state_d = S_BUSY;
                  end
`else
                  OP_MADD, OP_MSUB: begin
                     // Accumulate ops not built: treated as no-ops.
                  end
`endif
                  default: begin
                  end
               endcase
            end
         end

         S_BUSY: begin
            // Counter was loaded with N at the accepting edge, so it reads
            // 1 at the Nth edge afterwards: that edge commits the result.
            // Any start seen here, including one on the final edge, is dropped.
            if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
               case (mode_q)
                  MODE_LOAD: {hi_d, lo_d} = res_q;
                  MODE_ADD:  {hi_d, lo_d} = acc + res_q;
                  MODE_SUB:  {hi_d, lo_d} = acc - res_q;
                  default: begin
                  end
               endcase
            end else begin
               cnt_d = cnt_q - CNT_LAST;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_LOAD;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         res_q   <= 64'd0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu
// Purpose  : Self-checking bench for mdu. Stimulus pushes the expected
//            {HI, LO, busy length} of every accepted mult/div onto a
//            scoreboard queue; a monitor pops and compares whenever busy
//            falls. Immediate effects (reset, MTHI/MTLO, ignored starts)
//            are checked directly by the stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   mdu #(
      .MULT_CYCLES (MC),
      .DIV_CYCLES  (DC)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] cyc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] h, input logic [31:0] l, input int c);
      exp_t e;
      e.hi  = h;
      e.lo  = l;
      e.cyc = 32'(c);
      sb.push_back(e);
   endtask

   // Called at posedge+1; start is sampled on the next posedge and the
   // task returns at posedge+1 after that accepting edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start   = 1'b1;
      op      = o;
      rs_data = a;
      rt_data = b;
      @(posedge clk);
      #1;
      start   = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 40) begin
         tests++;
         fails++;
         $display("FAIL wait_idle: busy=%b still high after %0d cycles, expected 0", busy, n);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Monitor: counts busy cycles and checks HI/LO at each busy fall.
   // ------------------------------------------------------------------
   logic        busy_prev = 1'b0;
   logic [31:0] busy_cnt  = 32'd0;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         busy_prev = 1'b0;
         busy_cnt  = 32'd0;
      end else begin
         if (busy === 1'b1) begin
            busy_cnt++;
         end else if (busy_prev) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_completion: hi=%h lo=%h with empty scoreboard", hi, lo);
            end else begin
               e = sb.pop_front();
               check32("done_hi", hi, e.hi);
               check32("done_lo", lo, e.lo);
               check32("busy_cycles", busy_cnt, e.cyc);
            end
            busy_cnt = 32'd0;
         end
         busy_prev = (busy === 1'b1);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      op      = 3'd0;
      rs_data = 32'd0;
      rt_data = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check32("reset_busy", {31'd0, busy}, 32'd0);
      check32("reset_hi", hi, 32'd0);
      check32("reset_lo", lo, 32'd0);

      // MULT -2 * 3 = -6
      push(32'hFFFFFFFF, 32'hFFFFFFFA, MC);
      issue(3'd0, 32'hFFFFFFFE, 32'd3);
      check32("mult_busy_rise", {31'd0, busy}, 32'd1);
      wait_idle();

      // MULTU 0xFFFFFFFE * 3 = 0x2_FFFFFFFA
      push(32'h00000002, 32'hFFFFFFFA, MC);
      issue(3'd1, 32'hFFFFFFFE, 32'd3);
      wait_idle();

      // MULT -1 * -1 = 1 ; MULTU 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
      push(32'h00000000, 32'h00000001, MC);
      issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle();
      push(32'hFFFFFFFE, 32'h00000001, MC);
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle();

      // DIV -7 / 2 -> q=-3, r=-1
      push(32'hFFFFFFFF, 32'hFFFFFFFD, DC);
      issue(3'd2, 32'hFFFFFFF9, 32'd2);
      check32("div_busy_rise", {31'd0, busy}, 32'd1);
      wait_idle();

      // DIVU 7 / 0 -> HI/LO unchanged
      push(32'hFFFFFFFF, 32'hFFFFFFFD, DC);
      issue(3'd3, 32'd7, 32'd0);
      wait_idle();

      // DIV 7 / -2 -> q=-3, r=1
      push(32'h00000001, 32'hFFFFFFFD, DC);
      issue(3'd2, 32'd7, 32'hFFFFFFFE);
      wait_idle();

      // DIV overflow 0x80000000 / -1
      push(32'h00000000, 32'h80000000, DC);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_idle();

      // DIVU 100 / 7 -> q=14, r=2 (unsigned path with bit31 set would be signed)
      push(32'h00000002, 32'h0000000E, DC);
      issue(3'd3, 32'd100, 32'd7);
      wait_idle();

      // MULT 0x10000^2 with MTHI while busy -> MTHI ignored
      push(32'h00000001, 32'h00000000, MC);
      issue(3'd0, 32'h00010000, 32'h00010000);
      idle_cycles(1);
      issue(3'd4, 32'h00001234, 32'd0);
      wait_idle();
      check32("mthi_ignored_hi", hi, 32'h00000001);

      // MTLO / MTHI in idle
      issue(3'd5, 32'h00000055, 32'd0);
      check32("mtlo_lo", lo, 32'h00000055);
      check32("mtlo_busy", {31'd0, busy}, 32'd0);
      check32("mtlo_hi_kept", hi, 32'h00000001);
      issue(3'd4, 32'h0000ABCD, 32'd0);
      check32("mthi_hi", hi, 32'h0000ABCD);

      // Start on the completing edge is not accepted
      push(32'h00000000, 32'h00000006, MC);
      issue(3'd0, 32'd2, 32'd3);
      idle_cycles(MC - 1);
      issue(3'd5, 32'h00000099, 32'd0);
      check32("edge_start_lo", lo, 32'h00000006);
      check32("edge_start_busy", {31'd0, busy}, 32'd0);
      idle_cycles(1);
      check32("edge_start_lo_later", lo, 32'h00000006);

      // Reset mid-DIV aborts the operation
      issue(3'd2, 32'd100, 32'd7);
      idle_cycles(2);
      reset = 1'b1;
      idle_cycles(1);
      reset = 1'b0;
      check32("abort_busy", {31'd0, busy}, 32'd0);
      check32("abort_hi", hi, 32'd0);
      check32("abort_lo", lo, 32'd0);
      idle_cycles(DC + 5);
      check32("abort_hi_later", hi, 32'd0);
      check32("abort_lo_later", lo, 32'd0);
      check32("abort_busy_later", {31'd0, busy}, 32'd0);

      // MADD / MSUB
      issue(3'd5, 32'hFFFFFFFF, 32'd0);
      check32("pre_madd_lo", lo, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
      push(32'h00000001, 32'h00000000, MC);
      issue(3'd6, 32'd1, 32'd1);
      check32("madd_busy_rise", {31'd0, busy}, 32'd1);
      wait_idle();
      push(32'h00000000, 32'hFFFFFFFA, MC);
      issue(3'd7, 32'd2, 32'd3);
      wait_idle();
`else
      issue(3'd6, 32'd1, 32'd1);
      check32("madd_off_busy", {31'd0, busy}, 32'd0);
      idle_cycles(MC + 2);
      check32("madd_off_busy_later", {31'd0, busy}, 32'd0);
      check32("madd_off_hi", hi, 32'h00000000);
      check32("madd_off_lo", lo, 32'hFFFFFFFF);
      issue(3'd7, 32'd2, 32'd3);
      idle_cycles(MC + 2);
      check32("msub_off_hi", hi, 32'h00000000);
      check32("msub_off_lo", lo, 32'hFFFFFFFF);
`endif

      idle_cycles(3);
      check32("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
